// File: rtl/parity_frame_ctrl_if.sv
// Word-in / serial-out bus of the parity frame controller, plus the FSM state for debug.
interface parity_frame_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic             abort;
  logic             ser_out;
  logic             ser_valid;
  logic             par_out;
  logic             busy;
  logic             frame_done;
  logic [1:0]       state_dbg;

  modport master (
    output data_in, in_valid, abort,
    input  in_ready, ser_out, ser_valid, par_out, busy, frame_done, state_dbg
  );

  modport slave (
    input  data_in, in_valid, abort,
    output in_ready, ser_out, ser_valid, par_out, busy, frame_done, state_dbg
  );
endinterface

// File: rtl/parity_frame_ctrl.sv
// Serialises a word LSB-first and appends its even/odd parity bit.
// Optional trailing stop bit when PARITY_FRAME_STOP_BIT_EN is defined.
module parity_frame_ctrl #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input logic CLK,
  input logic reset_n,
  parity_frame_ctrl_if.slave bus
);
  // Handshake: a word transfers on any rising CLK edge where in_valid and in_ready are both 1;
  // in_ready is high only in IDLE and the producer must hold data_in/in_valid until then.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
`ifdef PARITY_FRAME_STOP_BIT_EN
    , S_STOP = 2'd3
`endif
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             acc;
  logic             par_q;
  logic             done_q;
  logic             last_bit;

`ifdef PARITY_FRAME_STOP_BIT_EN
  assign last_bit = (state == S_STOP);
`else
  assign last_bit = (state == S_PARITY);
`endif

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (bus.in_valid) state_n = S_SHIFT;
      S_SHIFT: begin
        if (bus.abort)             state_n = S_IDLE;
        else if (cnt == CNT_LAST)  state_n = S_PARITY;
      end
      S_PARITY: begin
`ifdef PARITY_FRAME_STOP_BIT_EN
        state_n = bus.abort ? S_IDLE : S_STOP;
`else
        state_n = S_IDLE;
`endif
      end
`ifdef PARITY_FRAME_STOP_BIT_EN
      S_STOP:   state_n = S_IDLE;
`endif
      default:  state_n = S_IDLE;
    endcase
  end

  // Datapath: the accumulator restarts on every accepted word.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      cnt   <= '0;
      acc   <= 1'b0;
    end else if (state == S_IDLE && bus.in_valid) begin
      shreg <= bus.data_in;
      cnt   <= '0;
      acc   <= 1'b0;
    end else if (state == S_SHIFT) begin
      shreg <= shreg >> 1;
      cnt   <= cnt + 1'b1;
      acc   <= acc ^ shreg[0];
    end
  end

  // Abort suppresses both the parity capture and the completion pulse.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      par_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_bit && !bus.abort;
      if (state == S_PARITY && !bus.abort) par_q <= acc ^ ODD;
    end
  end

  always_comb begin
    bus.ser_out = 1'b0;
    case (state)
      S_SHIFT:  bus.ser_out = shreg[0];
      S_PARITY: bus.ser_out = acc ^ ODD;
`ifdef PARITY_FRAME_STOP_BIT_EN
      S_STOP:   bus.ser_out = 1'b1;
`endif
      default:  bus.ser_out = 1'b0;
    endcase
  end

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.ser_valid  = (state != S_IDLE);
  assign bus.par_out    = par_q;
  assign bus.frame_done = done_q;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed bench: even-parity unit (u=0) and odd-parity unit (u=1) on one clock.
module tb_parity_frame_ctrl;
`ifdef PARITY_FRAME_STOP_BIT_EN
  localparam int PERIOD = 11;
`else
  localparam int PERIOD = 10;
`endif

  logic CLK = 1'b0;
  logic reset_n = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic o_sv, o_so, o_fd, o_po, o_bz, o_ir;

  parity_frame_ctrl_if #(.WIDTH(8)) b0 ();
  parity_frame_ctrl_if #(.WIDTH(8)) b1 ();

  parity_frame_ctrl #(.WIDTH(8), .ODD(1'b0)) dut0 (.CLK(CLK), .reset_n(reset_n), .bus(b0));
  parity_frame_ctrl #(.WIDTH(8), .ODD(1'b1)) dut1 (.CLK(CLK), .reset_n(reset_n), .bus(b1));

  // clock / reset
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_in(input int u, input logic v, input logic [7:0] d, input logic a);
    if (u == 0) begin b0.in_valid = v; b0.data_in = d; b0.abort = a; end
    else        begin b1.in_valid = v; b1.data_in = d; b1.abort = a; end
  endtask

  task automatic sample(input int u);
    if (u == 0) begin
      o_sv = b0.ser_valid; o_so = b0.ser_out; o_fd = b0.frame_done;
      o_po = b0.par_out;   o_bz = b0.busy;    o_ir = b0.in_ready;
    end else begin
      o_sv = b1.ser_valid; o_so = b1.ser_out; o_fd = b1.frame_done;
      o_po = b1.par_out;   o_bz = b1.busy;    o_ir = b1.in_ready;
    end
  endtask

  // Sends one word and checks every serial bit; returns at the frame_done cycle.
  task automatic frame(input int u, input logic [7:0] d, input logic exp_par,
                       input string tag, output int acc_cyc);
    set_in(u, 1'b1, d, 1'b0);
    tick();
    acc_cyc = cyc;
    set_in(u, 1'b0, d, 1'b0);
    for (int i = 0; i < 8; i++) begin
      sample(u);
      check({tag, "_data_valid"}, o_sv, 1'b1);
      check($sformatf("%s_bit%0d", tag, i), o_so, d[i]);
      tick();
    end
    sample(u);
    check({tag, "_par_valid"}, o_sv, 1'b1);
    check({tag, "_par_bit"}, o_so, exp_par);
    check({tag, "_no_early_done"}, o_fd, 1'b0);
    tick();
`ifdef PARITY_FRAME_STOP_BIT_EN
    sample(u);
    check({tag, "_stop_valid"}, o_sv, 1'b1);
    check({tag, "_stop_bit"}, o_so, 1'b1);
    check({tag, "_stop_no_done"}, o_fd, 1'b0);
    tick();
`endif
    sample(u);
    check({tag, "_done"}, o_fd, 1'b1);
    check({tag, "_par_out"}, o_po, exp_par);
    check({tag, "_idle_valid"}, o_sv, 1'b0);
    check({tag, "_idle_ready"}, o_ir, 1'b1);
  endtask

  initial begin
    int a0, a1;
    set_in(0, 1'b0, 8'h00, 1'b0);
    set_in(1, 1'b0, 8'h00, 1'b0);
    reset_n = 1'b0;
    #11;
    sample(0);
    check("rst_ready", o_ir, 1'b1);
    check("rst_valid", o_sv, 1'b0);
    check("rst_ser_out", o_so, 1'b0);
    check("rst_busy", o_bz, 1'b0);
    check("rst_par_out", o_po, 1'b0);
    check("rst_done", o_fd, 1'b0);
    check("rst_state", b0.state_dbg, 2'd0);
    #1 reset_n = 1'b1;
    tick();

    // 1: 8'hB5, even parity
    frame(0, 8'hB5, 1'b1, "t1", a0);
    tick();
    sample(0);
    check("t1_done_one_cycle", o_fd, 1'b0);

    // 2: back-to-back 00 then FF; second accept lands in the frame_done cycle
    frame(0, 8'h00, 1'b0, "t2a", a0);
    frame(0, 8'hFF, 1'b0, "t2b", a1);
    check("t2_accept_period", a1 - a0, PERIOD);
    tick();

    // 3: odd-parity unit
    frame(1, 8'h03, 1'b1, "t3a", a0);
    frame(1, 8'h01, 1'b0, "t3b", a0);
    tick();

    // 4: asynchronous reset mid-frame (par_out of unit 0 is 0 after 8'hFF; raise it first)
    frame(0, 8'hB5, 1'b1, "t4pre", a0);
    tick();
    set_in(0, 1'b1, 8'hB5, 1'b0);
    tick();
    set_in(0, 1'b0, 8'hB5, 1'b0);
    tick(); tick(); tick();
    sample(0);
    check("t4_bit3_before_rst", o_so, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    sample(0);
    check("t4_rst_valid", o_sv, 1'b0);
    check("t4_rst_busy", o_bz, 1'b0);
    check("t4_rst_par_out", o_po, 1'b0);
    check("t4_rst_done", o_fd, 1'b0);
    #3 reset_n = 1'b1;
    tick();
    sample(0);
    check("t4_ready_after", o_ir, 1'b1);
    check("t4_no_done_after", o_fd, 1'b0);
    frame(0, 8'hB5, 1'b1, "t4", a0);
    tick();

    // 5: abort in the parity cycle keeps the previous par_out (0 from 8'h00)
    frame(0, 8'h00, 1'b0, "t5pre", a0);
    tick();
    set_in(0, 1'b1, 8'hB5, 1'b0);
    tick();
    set_in(0, 1'b0, 8'hB5, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    sample(0);
    check("t5_par_cycle_bit", o_so, 1'b1);
    set_in(0, 1'b0, 8'hB5, 1'b1);
    tick();
    set_in(0, 1'b0, 8'hB5, 1'b0);
    sample(0);
    check("t5_abort_idle", o_bz, 1'b0);
    check("t5_abort_no_done", o_fd, 1'b0);
    check("t5_abort_par_kept", o_po, 1'b0);
    tick();
    sample(0);
    check("t5_abort_no_late_done", o_fd, 1'b0);

    // abort in IDLE does not block an accept; abort in SHIFT returns to IDLE
    set_in(0, 1'b1, 8'hB5, 1'b1);
    tick();
    sample(0);
    check("t5_idle_abort_accept", o_bz, 1'b1);
    check("t5_idle_abort_bit0", o_so, 1'b1);
    set_in(0, 1'b0, 8'hB5, 1'b1);
    tick();
    set_in(0, 1'b0, 8'hB5, 1'b0);
    sample(0);
    check("t5_shift_abort_idle", o_bz, 1'b0);
    check("t5_shift_abort_par", o_po, 1'b0);
    tick();
    sample(0);
    check("t5_shift_abort_no_done", o_fd, 1'b0);

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
